pipelined_adder: RTL and testbench



---
 rtl/adder_pkg.sv | 16 +
 rtl/pipelined_adder_if.sv | 28 ++
 rtl/seg_adder.sv | 37 +++
 rtl/pipelined_adder.sv | 93 +++++++++
 tb/tb_pipelined_adder.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared geometry for the segmented pipelined adder: default sizes,
// the stage-count helper and the configuration legality check.
package adder_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SEG   = 4;

  function automatic bit cfg_ok(input int width, input int seg);
    return (seg >= 1) && (width >= seg) && ((width % seg) == 0);
  endfunction

  function automatic int stages(input int width, input int seg);
    return (seg >= 1) ? (width / seg) : 1;
  endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// master = producer/consumer side, slave = the adder.
interface pipelined_adder_if #(
  parameter int WIDTH = adder_pkg::DEF_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/seg_adder.sv
// Combinational SEG-bit ripple adder made of half-adder pairs per bit;
// also reports the carry into its MSB so the caller can form signed overflow.
module seg_adder
  import adder_pkg::*;
#(
  parameter int SEG = DEF_SEG
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           cmsb
);

  always_comb begin : ripple
    logic c;
    logic p;
    logic g;
    sum  = '0;
    cmsb = 1'b0;
    c    = cin;
    p    = 1'b0;
    g    = 1'b0;
    for (int i = 0; i < SEG; i++) begin
      p      = a[i] ^ b[i];
      g      = a[i] & b[i];
      sum[i] = p ^ c;
      if (i == SEG - 1) begin
        cmsb = c;
      end
      c = g | (p & c);
    end
    cout = c;
  end

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit a+b+cin with the carry chain cut into SEG-bit stages; latency STAGES cycles.
// A stalled output (out_valid && !out_ready) freezes every stage and drops in_ready.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG
) (
  input logic              clk,
  input logic              rst_n,
  pipelined_adder_if.slave io
);

  localparam int STAGES = stages(WIDTH, SEG);
  localparam int LAST   = STAGES - 1;

  if (!cfg_ok(WIDTH, SEG)) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a positive multiple of SEG");
  end

  // c is the carry entering a stage on st_in and the carry leaving it on st_q.
  typedef struct packed {
    logic             vld;
    logic             c;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
  } stage_t;

  stage_t            st_in   [STAGES];
  stage_t            st_d    [STAGES];
  stage_t            st_q    [STAGES];
  logic [SEG-1:0]    seg_sum [STAGES];
  logic [STAGES-1:0] seg_co;
  logic [STAGES-1:0] seg_cm;
  logic              msb_c_q;
  logic              adv;

  assign adv         = !st_q[LAST].vld || io.out_ready;
  assign io.in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign st_in[k] = '{vld: io.in_valid, c: io.cin, a: io.a, b: io.b, s: '0};
    end else begin : g_body
      assign st_in[k] = st_q[k-1];
    end

    seg_adder #(
      .SEG (SEG)
    ) u_seg (
      .a    (st_in[k].a[k*SEG +: SEG]),
      .b    (st_in[k].b[k*SEG +: SEG]),
      .cin  (st_in[k].c),
      .sum  (seg_sum[k]),
      .cout (seg_co[k]),
      .cmsb (seg_cm[k])
    );
  end

  // Skew (upper a/b) and deskew (finished lower sum) travel with each beat.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      st_d[k]                 = st_in[k];
      st_d[k].c               = seg_co[k];
      st_d[k].s[k*SEG +: SEG] = seg_sum[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        st_q[k] <= '0;
      end
      msb_c_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        st_q[k] <= st_d[k];
      end
      msb_c_q <= seg_cm[LAST];
    end
  end

  assign io.out_valid = st_q[LAST].vld;
  assign io.sum       = st_q[LAST].s;
  assign io.cout      = st_q[LAST].c;
  assign io.ovf       = st_q[LAST].c ^ msb_c_q;

  // Operand copies in the final stage and intermediate MSB carries are dead ends.
  logic unused_bits;
  assign unused_bits = ^{seg_cm, st_q[LAST].a, st_q[LAST].b};

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and random stimulus for pipelined_adder against an arithmetic reference.
module tb_pipelined_adder;

  localparam int W = 16;
  localparam int S = 4;
  localparam longint SMAX = (longint'(1) << (W - 1)) - 1;
  localparam longint SMIN = -(longint'(1) << (W - 1));

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } res_t;

  logic         clk;
  logic         rst_n;
  int           checks = 0;
  int           errors = 0;
  res_t         exp_q[$];
  logic [W-1:0] hold_sum;
  logic         hold_cout;
  logic         hold_ovf;
  bit           was_stall;

  pipelined_adder_if #(.WIDTH(W)) ifc ();

  pipelined_adder #(
    .WIDTH (W),
    .SEG   (S)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, expv);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    res_t   r;
    longint u;
    longint s;
    u   = longint'(x) + longint'(y) + longint'(c);
    s   = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
    r.s = u[W-1:0];
    r.c = u[W];
    r.o = (s > SMAX) || (s < SMIN);
    return r;
  endfunction

  // Scoreboard: results leave in acceptance order; a stalled output must not move.
  initial begin : monitor
    res_t r;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        exp_q.delete();
        was_stall = 1'b0;
      end else begin
        if (was_stall) begin
          check("stall_hold_valid", ifc.out_valid, 1);
          check("stall_hold_sum", ifc.sum, hold_sum);
          check("stall_hold_cout", ifc.cout, hold_cout);
          check("stall_hold_ovf", ifc.ovf, hold_ovf);
        end
        was_stall = ifc.out_valid && !ifc.out_ready;
        hold_sum  = ifc.sum;
        hold_cout = ifc.cout;
        hold_ovf  = ifc.ovf;
        if (ifc.out_valid && ifc.out_ready) begin
          check("result_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            check("model_sum", ifc.sum, r.s);
            check("model_cout", ifc.cout, r.c);
            check("model_ovf", ifc.ovf, r.o);
          end
        end
        if (ifc.in_valid && ifc.in_ready) begin
          exp_q.push_back(model(ifc.a, ifc.b, ifc.cin));
        end
      end
    end
  end

  // Entered and left at posedge+1 with an empty pipeline and out_ready=1.
  task automatic directed(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tbv,
                          input logic tc, input logic [W-1:0] es, input logic ec, input logic eo);
    int k;
    ifc.a        = ta;
    ifc.b        = tbv;
    ifc.cin      = tc;
    ifc.in_valid = 1'b1;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    k = 1;
    @(negedge clk);
    while (ifc.out_valid !== 1'b1 && k < 20) begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    check({tag, "_latency"}, k, 4);
    check({tag, "_sum"}, ifc.sum, es);
    check({tag, "_cout"}, ifc.cout, ec);
    check({tag, "_ovf"}, ifc.ovf, eo);
    @(posedge clk); #1;
  endtask

  task automatic stream(input int n, input bit alt, input int stall_at, input bit gapchk,
                        output int cycles);
    int sent = 0;
    int cyc  = 0;
    bit xfer;
    bit hist[$];
    ifc.a         = 16'($urandom);
    ifc.b         = 16'($urandom);
    ifc.cin       = 1'($urandom);
    ifc.in_valid  = 1'b1;
    ifc.out_ready = 1'b1;
    while (sent < n && cyc < 200) begin
      @(negedge clk);
      xfer = ifc.in_valid && ifc.in_ready;
      if (!ifc.out_ready) begin
        check("stall_in_ready", ifc.in_ready, 0);
      end
      if (gapchk) begin
        if (hist.size() >= 4) begin
          check("gap_pattern", ifc.out_valid, hist[hist.size()-4]);
        end
        hist.push_back(xfer);
      end
      @(posedge clk); #1;
      cyc++;
      if (xfer) begin
        sent++;
        ifc.a   = 16'($urandom);
        ifc.b   = 16'($urandom);
        ifc.cin = 1'($urandom);
      end
      ifc.out_ready = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 5);
      ifc.in_valid  = (sent < n) && (!alt || (cyc % 2 == 0));
    end
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    cycles = cyc;
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin : stim
    int n;
    rst_n         = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.a         = '0;
    ifc.b         = '0;
    ifc.cin       = 1'b0;
    ifc.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", ifc.out_valid, 0);
    check("reset_in_ready", ifc.in_ready, 1);
    check("reset_sum", ifc.sum, 0);
    check("reset_cout", ifc.cout, 0);
    check("reset_ovf", ifc.ovf, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    directed("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    directed("ripple", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    directed("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed("ovf_neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    stream(8, 1'b0, 5, 1'b0, n);
    check("stall_stream_cycles", n, 13);
    drain();
    stream(8, 1'b1, -1, 1'b1, n);
    check("bubble_stream_cycles", n, 15);
    drain();
    stream(8, 1'b0, -1, 1'b1, n);
    check("full_rate_cycles", n, 8);
    drain();

    // Five back-to-back beats: one at the output and three still in flight.
    for (int i = 0; i < 5; i++) begin
      ifc.a        = 16'($urandom);
      ifc.b        = 16'($urandom);
      ifc.cin      = 1'($urandom);
      ifc.in_valid = 1'b1;
      @(posedge clk); #1;
    end
    ifc.in_valid = 1'b0;
    check("pre_reset_valid", ifc.out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_valid", ifc.out_valid, 0);
    check("async_reset_sum", ifc.sum, 0);
    check("async_reset_in_ready", ifc.in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("no_stale_beat", ifc.out_valid, 0);
    end
    @(posedge clk); #1;
    directed("post_reset", 16'h0F0F, 16'h0101, 1'b1, 16'h1011, 1'b0, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
